lfsr_weight_gen: RTL and testbench

Multi-lane, parametrised pseudo-random weight generator for initialising network weight matrices. It holds LANES independent Galois LFSRs of WIDTH bits. On a start request it streams a programmed number of weight words over a valid/ready interface, with optional arithmetic down-scaling. It sits between the network controller (start/count/seed) and the weight-matrix write path (data sink).

---
 rtl/lfsr_weight_gen.sv | 95 +++++++++
 tb/tb_lfsr_weight_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_weight_gen.sv
// rtl/lfsr_weight_gen.sv - multi-lane Galois LFSR weight generator with valid/ready streaming
module lfsr_weight_gen #(
  parameter int                WIDTH = 16,
  parameter int                LANES = 4,
  parameter logic [WIDTH-1:0]  TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0]  SEED  = 16'hACE1,
  parameter int                CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CNT_W-1:0]         count,
  input  logic [3:0]               shift,
  input  logic                     seed_load,
  input  logic [LANES*WIDTH-1:0]   seed_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   out_data,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] lane_q [LANES];
  logic [CNT_W-1:0] remaining;
  logic [3:0]       shift_q;
  logic             zero_done;
  logic             xfer;
  logic             accept;

  // Lane i resets to SEED rotated left by i; a zero result would lock the LFSR.
  function automatic logic [WIDTH-1:0] reset_seed(input int i);
    logic [WIDTH-1:0] s;
    int r;
    r = i % WIDTH;
    if (r == 0) s = SEED;
    else        s = (SEED << r) | (SEED >> (WIDTH - r));
    return (s == '0) ? ONE : s;
  endfunction

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  assign xfer   = (state == RUN) && out_ready;
  assign accept = (state == IDLE) && start && (count != '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (out_ready && remaining == CNT_W'(1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      shift_q   <= '0;
      zero_done <= 1'b0;
      for (int i = 0; i < LANES; i++) lane_q[i] <= reset_seed(i);
    end else begin
      state     <= state_nxt;
      zero_done <= (state == IDLE) && start && (count == '0);
      if (accept) begin
        remaining <= count;
        shift_q   <= shift;
      end else if (xfer) begin
        remaining <= remaining - CNT_W'(1);
      end
      for (int i = 0; i < LANES; i++) begin
        if (state == IDLE && seed_load)
          lane_q[i] <= (seed_in[i*WIDTH +: WIDTH] == '0) ? ONE : seed_in[i*WIDTH +: WIDTH];
        else if (xfer)
          lane_q[i] <= lfsr_step(lane_q[i]);
      end
    end
  end

  assign out_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == FIN) || zero_done;

  for (genvar g = 0; g < LANES; g++) begin : g_out
    assign out_data[g*WIDTH +: WIDTH] = $signed(lane_q[g]) >>> shift_q;
  end

endmodule

// File: tb/tb_lfsr_weight_gen.sv
// tb/tb_lfsr_weight_gen.sv - self-checking bench for lfsr_weight_gen against a behavioural model
module tb_lfsr_weight_gen;
  localparam int W = 16;
  localparam int L = 4;
  localparam int C = 16;
  localparam int TAPS_I = 'hB400;
  localparam int SEED_I = 'hACE1;

  logic           clk = 0;
  logic           rst = 1;
  logic           start = 0;
  logic [C-1:0]   count = '0;
  logic [3:0]     shift = '0;
  logic           seed_load = 0;
  logic [L*W-1:0] seed_in = '0;
  logic           out_valid;
  logic           out_ready = 0;
  logic [L*W-1:0] out_data;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  lfsr_weight_gen dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .shift(shift),
    .seed_load(seed_load), .seed_in(seed_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Model: phase 0 idle, 1 streaming, 2 end-of-run pulse
  int m_lane [L];
  int m_phase, m_rem, m_shift;
  bit m_zdone;

  function automatic int next_val(input int s);
    return (s / 2) ^ ((s % 2 == 1) ? TAPS_I : 0);
  endfunction

  function automatic int rot_seed(input int i);
    int s;
    s = ((SEED_I << i) | (SEED_I >> (W - i))) & 'hFFFF;
    return (s == 0) ? 1 : s;
  endfunction

  function automatic logic [W-1:0] model_word(input int i);
    int v;
    v = m_lane[i];
    if (v >= 32768) v = v - 65536;
    v = v >>> m_shift;
    return v[W-1:0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < L; i++) m_lane[i] = rot_seed(i);
      m_phase = 0; m_rem = 0; m_shift = 0; m_zdone = 0;
    end else begin
      m_zdone = 0;
      case (m_phase)
        0: begin
          if (seed_load)
            for (int i = 0; i < L; i++) begin
              m_lane[i] = int'(seed_in[i*W +: W]);
              if (m_lane[i] == 0) m_lane[i] = 1;
            end
          if (start) begin
            if (count != 0) begin m_rem = int'(count); m_shift = int'(shift); m_phase = 1; end
            else m_zdone = 1;
          end
        end
        1: if (out_ready) begin
          for (int i = 0; i < L; i++) m_lane[i] = next_val(m_lane[i]);
          m_rem = m_rem - 1;
          if (m_rem == 0) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_valid", 64'(out_valid), 64'(m_phase == 1));
      chk("model_busy", 64'(busy), 64'(m_phase == 1));
      chk("model_done", 64'(done), 64'(m_phase == 2 || m_zdone));
      for (int i = 0; i < L; i++)
        chk($sformatf("model_data%0d", i), 64'(out_data[i*W +: W]), 64'(model_word(i)));
    end
  end

  function automatic logic [W-1:0] lane(input int i);
    return out_data[i*W +: W];
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; cyc(); rst = 0; cyc();
  endtask

  initial begin
    cyc(); cyc();
    rst = 0; chk_en = 1;
    // Reset values
    chk("reset_lane0", 64'(lane(0)), 64'hACE1);
    chk("reset_lane1", 64'(lane(1)), 64'h59C3);
    chk("reset_model_lane1", 64'(m_lane[1]), 64'h59C3);
    chk("reset_ctl", {61'd0, out_valid, busy, done}, 64'd0);

    // Stream with ready high
    start = 1; count = 3; shift = 0; out_ready = 1; cyc();
    start = 0;
    chk("stream_w0", 64'(lane(0)), 64'hACE1); chk("stream_v0", 64'(out_valid), 64'd1); cyc();
    chk("stream_w1", 64'(lane(0)), 64'hE270); cyc();
    chk("stream_w2", 64'(lane(0)), 64'h7138); chk("stream_model_w2", 64'(m_lane[0]), 64'h7138); cyc();
    chk("stream_done", {62'd0, out_valid, done}, 64'd1); cyc();
    chk("stream_after", {62'd0, out_valid, done}, 64'd0);
    chk("stream_state", 64'(lane(0)), 64'h389C);

    // Backpressure
    do_reset();
    start = 1; count = 2; out_ready = 0; cyc();
    start = 0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_hold", 64'(lane(0)), 64'hACE1);
      cyc();
    end
    out_ready = 1;
    chk("bp_w0", 64'(lane(0)), 64'hACE1); cyc();
    chk("bp_w1", 64'(lane(0)), 64'hE270); cyc();
    chk("bp_done", 64'(done), 64'd1); cyc();

    // Seed load with a zero lane
    seed_load = 1; seed_in = 64'h1111_2222_3333_0000; cyc();
    seed_load = 0;
    chk("seed_lane0", 64'(lane(0)), 64'h0001);
    chk("seed_lane1", 64'(lane(1)), 64'h3333);
    start = 1; count = 2; cyc();
    start = 0;
    chk("seed_w0", 64'(lane(0)), 64'h0001); cyc();
    chk("seed_w1", 64'(lane(0)), 64'hB400); cyc();
    chk("seed_done", 64'(done), 64'd1); cyc();

    // Shift and zero count
    do_reset();
    start = 1; count = 1; shift = 4; out_ready = 0; cyc();
    start = 0;
    chk("shift_w", 64'(lane(0)), 64'hFACE);
    out_ready = 1; cyc(); cyc();
    start = 1; count = 0; shift = 0; cyc();
    start = 0;
    chk("zero_done", {62'd0, out_valid, done}, 64'd1); cyc();
    chk("zero_after", {62'd0, out_valid, done}, 64'd0);

    // Start ignored while running
    do_reset();
    start = 1; count = 3; out_ready = 1; cyc();
    start = 0; cyc();
    start = 1; count = 1; cyc();
    start = 0;
    chk("ign_busy", 64'(busy), 64'd1);
    chk("ign_w2", 64'(lane(0)), 64'h7138); cyc();
    chk("ign_done", 64'(done), 64'd1); cyc();

    // Reset mid-run
    do_reset();
    start = 1; count = 10; out_ready = 1; cyc();
    start = 0; cyc(); cyc(); cyc();
    chk("mid_w3", 64'(lane(0)), 64'h389C);
    rst = 1; cyc();
    rst = 0;
    chk("mid_rst_ctl", {61'd0, out_valid, busy, done}, 64'd0);
    chk("mid_rst_lane0", 64'(lane(0)), 64'hACE1); cyc();
    chk("mid_rst_nodone", 64'(done), 64'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 5) == 0);
      count     = C'($urandom_range(0, 6));
      shift     = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      seed_load = ($urandom_range(0, 11) == 0);
      seed_in   = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) seed_in[$urandom_range(0, L-1)*W +: W] = '0;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
